mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer sharing one single-ported memory between the instruction-fetch path and the load/store path of the CPU datapath. It accepts one transaction at a time from either port, drives the memory with a held request until the memory acknowledges, and returns the result to the port that issued it. It sits between the datapath's fetch/data-memory interfaces and the unified memory, and is instantiated alongside the control unit in the CPU top.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data single-port memory arbiter and sequencer (optional MEM_ARB_RR_EN: round-robin arbitration)
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic                    o_if_gnt,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    input  logic                    i_dm_req,
    input  logic                    i_dm_we,
    input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_dm_be,
    output logic                    o_dm_gnt,
    output logic                    o_dm_rvalid,
    output logic [DATA_WIDTH-1:0]   o_dm_rdata,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_ack,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pick_dm;

`ifdef MEM_ARB_RR_EN
    logic last_dm;

    // Remember which port won the most recent grant; reset favours data first.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_dm <= 1'b0;
        end else if (o_if_gnt || o_dm_gnt) begin
            last_dm <= o_dm_gnt;
        end
    end

    // On a conflict the port that did not win last time goes first.
    always_comb begin
        if (i_dm_req && i_if_req) begin
            pick_dm = !last_dm;
        end else begin
            pick_dm = i_dm_req;
        end
    end
`else
    // Data always beats fetch; a lone fetch still wins because pick_dm is low.
    always_comb begin
        pick_dm = i_dm_req;
    end
`endif

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave IDLE on a grant, return on memory ack.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (o_dm_gnt) begin
                    state_nxt = BUSY_DM;
                end else if (o_if_gnt) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (i_mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are combinational in IDLE only; mem_req follows state so reset drops it at once.
    always_comb begin
        o_if_gnt  = 1'b0;
        o_dm_gnt  = 1'b0;
        if (state == IDLE && !i_reset) begin
            o_dm_gnt = pick_dm;
            o_if_gnt = i_if_req && !pick_dm;
        end
        o_mem_req = (state != IDLE);
        o_busy    = (state != IDLE);
    end

    // Capture the winner's command; fetches are always full-width reads.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
        end else if (o_dm_gnt) begin
            o_mem_we    <= i_dm_we;
            o_mem_addr  <= i_dm_addr;
            o_mem_wdata <= i_dm_wdata;
            o_mem_be    <= i_dm_be;
        end else if (o_if_gnt) begin
            o_mem_we    <= 1'b0;
            o_mem_addr  <= i_if_addr;
            o_mem_wdata <= '0;
            o_mem_be    <= '1;
        end
    end

    // Route the completion back to the issuing port; rdata holds until that port completes again.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_if_rvalid <= 1'b0;
            o_dm_rvalid <= 1'b0;
            o_if_rdata  <= '0;
            o_dm_rdata  <= '0;
        end else begin
            o_if_rvalid <= (state == BUSY_IF) && i_mem_ack;
            o_dm_rvalid <= (state == BUSY_DM) && i_mem_ack;
            if (state == BUSY_IF && i_mem_ack) begin
                o_if_rdata <= i_mem_rdata;
            end
            if (state == BUSY_DM && i_mem_ack) begin
                o_dm_rdata <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_if_req = 1'b0;
    logic [AW-1:0] i_if_addr = '0;
    logic          o_if_gnt;
    logic          o_if_rvalid;
    logic [DW-1:0] o_if_rdata;
    logic          i_dm_req = 1'b0;
    logic          i_dm_we = 1'b0;
    logic [AW-1:0] i_dm_addr = '0;
    logic [DW-1:0] i_dm_wdata = '0;
    logic [BW-1:0] i_dm_be = '0;
    logic          o_dm_gnt;
    logic          o_dm_rvalid;
    logic [DW-1:0] o_dm_rdata;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [BW-1:0] o_mem_be;
    logic          i_mem_ack = 1'b0;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          o_busy;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .i_dm_be(i_dm_be), .o_dm_gnt(o_dm_gnt),
        .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    typedef struct { logic [DW-1:0] d; bit care; } resp_t;
    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be; } cmd_t;

    resp_t exp_if_q[$];
    resp_t exp_dm_q[$];
    cmd_t  exp_cmd_q[$];
    bit    exp_gnt_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Memory model: acks on the ack_wait-th cycle of a request, rdata = addr ^ 0xFFFF0000 unless fixed.
    int            ack_wait = 1;
    bit            never_ack = 1'b0;
    bit            stray_ack = 1'b0;
    bit            use_fixed = 1'b0;
    logic [DW-1:0] fixed_rdata = '0;
    int            req_cnt = 0;
    always @(posedge i_clk) begin
        #2;
        if (o_mem_req) begin
            req_cnt     = req_cnt + 1;
            i_mem_ack   = !never_ack && (req_cnt == ack_wait);
            i_mem_rdata = use_fixed ? fixed_rdata : (o_mem_addr ^ 32'hFFFF_0000);
        end else begin
            req_cnt     = 0;
            i_mem_ack   = stray_ack;
            i_mem_rdata = 32'h5555_AAAA;
        end
    end

    // Monitor: compare grants, commands and responses against the scoreboard queues.
    logic  prev_req = 1'b0;
    bit    mb;
    cmd_t  mc;
    resp_t mr;
    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_if_gnt || o_dm_gnt) begin
                if (exp_gnt_q.size() == 0) begin
                    chk("gnt_unexpected", {o_dm_gnt, o_if_gnt}, 0);
                end else begin
                    mb = exp_gnt_q.pop_front();
                    chk("gnt_port", {o_dm_gnt, o_if_gnt}, mb ? 2'b10 : 2'b01);
                end
            end
            if (o_mem_req && !prev_req) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("cmd_unexpected", o_mem_req, 0);
                end else begin
                    mc = exp_cmd_q.pop_front();
                    chk("cmd_we", o_mem_we, mc.we);
                    chk("cmd_addr", o_mem_addr, mc.addr);
                    chk("cmd_be", o_mem_be, mc.be);
                    if (mc.we) chk("cmd_wdata", o_mem_wdata, mc.wdata);
                end
            end
            if (o_if_rvalid) begin
                if (exp_if_q.size() == 0) begin
                    chk("if_rvalid_unexpected", o_if_rvalid, 0);
                end else begin
                    mr = exp_if_q.pop_front();
                    if (mr.care) chk("if_rdata", o_if_rdata, mr.d);
                end
            end
            if (o_dm_rvalid) begin
                if (exp_dm_q.size() == 0) begin
                    chk("dm_rvalid_unexpected", o_dm_rvalid, 0);
                end else begin
                    mr = exp_dm_q.pop_front();
                    if (mr.care) chk("dm_rdata", o_dm_rdata, mr.d);
                end
            end
        end
        prev_req = o_mem_req;
    end

    task automatic wait_gnt(input bit dm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (dm ? o_dm_gnt : o_if_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        chk(dm ? "dm_gnt_timeout" : "if_gnt_timeout", ok, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (!o_busy && exp_if_q.size() == 0 && exp_dm_q.size() == 0 && exp_cmd_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("idle_timeout", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit ok, ok_d, ok_i, early, seen;
    int cnt, lat;
    localparam logic [DW-1:0] DM_RD [4] = '{32'hFFFF_0200, 32'hFFFF_0204, 32'hFFFF_0208, 32'hFFFF_020C};
    localparam logic [DW-1:0] IF_RD [4] = '{32'hFFFF_0300, 32'hFFFF_0304, 32'hFFFF_0308, 32'hFFFF_030C};

    initial begin
        // Reset with both requests active.
        i_if_req = 1'b1; i_if_addr = 32'h80;
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h40; i_dm_be = 4'hF;
        ack_wait = 2;
        repeat (3) @(negedge i_clk);
        chk("rst_if_gnt", o_if_gnt, 0);
        chk("rst_dm_gnt", o_dm_gnt, 0);
        chk("rst_if_rvalid", o_if_rvalid, 0);
        chk("rst_dm_rvalid", o_dm_rvalid, 0);
        chk("rst_if_rdata", o_if_rdata, 0);
        chk("rst_dm_rdata", o_dm_rdata, 0);
        chk("rst_mem_req", o_mem_req, 0);
        chk("rst_mem_we", o_mem_we, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        chk("rst_mem_be", o_mem_be, 0);
        chk("rst_busy", o_busy, 0);

        exp_gnt_q.push_back(1'b1);
        exp_gnt_q.push_back(1'b0);
        exp_cmd_q.push_back('{1'b0, 32'h40, 32'h0, 4'hF});
        exp_cmd_q.push_back('{1'b0, 32'h80, 32'h0, 4'hF});
        exp_dm_q.push_back('{32'hFFFF_0040, 1'b1});
        exp_if_q.push_back('{32'hFFFF_0080, 1'b1});
        @(posedge i_clk); #1 i_reset = 1'b0;
        @(negedge i_clk);
        chk("gnt_first_idle_cycle", o_dm_gnt, 1);
        @(posedge i_clk); #1 i_dm_req = 1'b0;

        // Fetch held while data is busy: grant only alongside the data rvalid.
        early = 1'b0; seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            if (o_dm_rvalid) begin
                seen = 1'b1;
                break;
            end
            if (o_if_gnt) early = 1'b1;
        end
        chk("if_gnt_while_busy", early, 0);
        chk("dm_rvalid_seen", seen, 1);
        chk("if_gnt_with_dm_rvalid", o_if_gnt, 1);
        @(posedge i_clk); #1 i_if_req = 1'b0;
        wait_idle();

        // Store with immediate ack.
        ack_wait = 1;
        exp_gnt_q.push_back(1'b1);
        exp_cmd_q.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3});
        exp_dm_q.push_back('{32'h0, 1'b0});
        @(posedge i_clk); #1;
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h100; i_dm_wdata = 32'hDEAD_BEEF; i_dm_be = 4'h3;
        wait_gnt(1'b1, ok);
        @(posedge i_clk); #1 i_dm_req = 1'b0; i_dm_we = 1'b0;
        wait_idle();
        chk("if_rdata_untouched", o_if_rdata, 32'hFFFF_0080);

        // Lone fetch, ack in the third request cycle.
        ack_wait = 3; use_fixed = 1'b1; fixed_rdata = 32'h0000_0093;
        exp_gnt_q.push_back(1'b0);
        exp_cmd_q.push_back('{1'b0, 32'h10, 32'h0, 4'hF});
        exp_if_q.push_back('{32'h0000_0093, 1'b1});
        @(posedge i_clk); #1 i_if_req = 1'b1; i_if_addr = 32'h10;
        wait_gnt(1'b0, ok);
        @(posedge i_clk); #1 i_if_req = 1'b0;
        cnt = 0; lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge i_clk);
            if (o_mem_req) cnt++;
            if (o_if_rvalid) begin
                lat = i;
                break;
            end
        end
        chk("fetch_mem_req_cycles", cnt, 3);
        chk("fetch_rvalid_cycle", lat, 4);
        wait_idle();
        use_fixed = 1'b0;

        // Four rounds of simultaneous held requests.
        ack_wait = 1;
        for (int r = 0; r < 8; r++) begin
            bit dm;
            int idx;
`ifdef MEM_ARB_RR_EN
            dm = (r % 2 == 0);
            idx = r / 2;
`else
            dm = (r < 4);
            idx = r % 4;
`endif
            exp_gnt_q.push_back(dm);
            exp_cmd_q.push_back('{1'b0, dm ? 32'h200 + 32'(idx * 4) : 32'h300 + 32'(idx * 4), 32'h0, 4'hF});
        end
        for (int i = 0; i < 4; i++) begin
            exp_dm_q.push_back('{DM_RD[i], 1'b1});
            exp_if_q.push_back('{IF_RD[i], 1'b1});
        end
        @(posedge i_clk); #1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_be = 4'hF;
                    i_dm_addr = 32'h200 + 32'(i * 4);
                    wait_gnt(1'b1, ok_d);
                    @(posedge i_clk); #1;
                end
                i_dm_req = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    i_if_req = 1'b1;
                    i_if_addr = 32'h300 + 32'(i * 4);
                    wait_gnt(1'b0, ok_i);
                    @(posedge i_clk); #1;
                end
                i_if_req = 1'b0;
            end
        join
        wait_idle();

        // Reset while a load waits for an ack that never comes.
        never_ack = 1'b1;
        exp_gnt_q.push_back(1'b1);
        exp_cmd_q.push_back('{1'b0, 32'h400, 32'h0, 4'hF});
        @(posedge i_clk); #1;
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h400; i_dm_be = 4'hF;
        wait_gnt(1'b1, ok);
        @(posedge i_clk); #1 i_dm_req = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("busy_before_reset", o_busy, 1);
        chk("mem_req_before_reset", o_mem_req, 1);
        #2 i_reset = 1'b1;
        #1;
        chk("mem_req_async_drop", o_mem_req, 0);
        chk("busy_async_drop", o_busy, 0);
        @(posedge i_clk); #1 i_reset = 1'b0; never_ack = 1'b0;
        stray_ack = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 stray_ack = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            if (o_busy || o_dm_rvalid || o_if_rvalid) early = 1'b1;
        end
        chk("stray_ack_ignored", early, 0);
        chk("dm_rdata_after_reset", o_dm_rdata, 0);
        chk("mem_addr_after_reset", o_mem_addr, 0);

        chk("gnt_queue_drained", exp_gnt_q.size(), 0);
        chk("cmd_queue_drained", exp_cmd_q.size(), 0);
        chk("if_queue_drained", exp_if_q.size(), 0);
        chk("dm_queue_drained", exp_dm_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
